// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, status codes, instruction
// lengths and the fetch FSM state type.
package y86_pkg;

  typedef enum logic [3:0] {
    I_HALT   = 4'h0,
    I_NOP    = 4'h1,
    I_CMOVXX = 4'h2,
    I_IRMOVQ = 4'h3,
    I_RMMOVQ = 4'h4,
    I_MRMOVQ = 4'h5,
    I_OPQ    = 4'h6,
    I_JXX    = 4'h7,
    I_CALL   = 4'h8,
    I_RET    = 4'h9,
    I_PUSHQ  = 4'hA,
    I_POPQ   = 4'hB
  } icode_e;

  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_e;

  // Instruction lengths in bytes
  localparam logic [3:0] LEN_SHORT = 4'd1;   // halt, nop, ret
  localparam logic [3:0] LEN_REG   = 4'd2;   // register byte only
  localparam logic [3:0] LEN_DEST  = 4'd9;   // constant word only
  localparam logic [3:0] LEN_FULL  = 4'd10;  // register byte + constant word

  // Register field value meaning "no register"
  localparam logic [3:0] REG_NONE = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DONE,
    S_HALTED
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_instr_length.sv
// Combinational icode classifier: instruction length, whether a register
// byte and/or a constant word follow, and whether the icode is illegal.
module instr_length
  import y86_pkg::*;
(
  input  logic [3:0] icode,
  output logic [3:0] length,
  output logic       need_regids,
  output logic       need_valc,
  output logic       invalid
);

  // Decode the instruction class from the icode nibble
  always_comb begin
    // NOTE: every output gets a default before the case so that no path
    // leaves one unassigned, which would otherwise infer a latch.
    length      = LEN_SHORT;
    need_regids = 1'b0;
    need_valc   = 1'b0;
    invalid     = 1'b0;
    case (icode)
      I_HALT, I_NOP, I_RET: length = LEN_SHORT;
      I_CMOVXX, I_OPQ, I_PUSHQ, I_POPQ: begin
        length      = LEN_REG;
        need_regids = 1'b1;
      end
      I_JXX, I_CALL: begin
        length    = LEN_DEST;
        need_valc = 1'b1;
      end
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
        length      = LEN_FULL;
        need_regids = 1'b1;
        need_valc   = 1'b1;
      end
      default: invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Y86-64 byte-serial instruction fetch: reads one byte per acknowledged
// memory cycle, decodes fields as they arrive, and presents the complete
// instruction with a one-cycle instr_valid pulse.
module fetch_unit
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] pc_in,
  input  logic        pc_load,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [7:0]  imem_data,
  input  logic        imem_err,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  ra,
  output logic [3:0]  rb,
  output logic [63:0] valc,
  output logic [63:0] valp,
  output logic        instr_valid,
  output logic [2:0]  stat,
  output logic        busy
);

  fetch_state_e state_q, state_d;
  logic [63:0]  pc_q;
  logic [3:0]   idx_q;

  // Working decode registers: filled byte by byte, copied to the outputs
  // only when the fetch finishes so the outputs hold between pulses.
  logic [3:0]   wk_icode_q, wk_ifun_q, wk_ra_q, wk_rb_q;
  logic [63:0]  wk_valc_q, wk_valp_q;
  logic [3:0]   wk_icode_d, wk_ifun_d, wk_ra_d, wk_rb_d;
  logic [63:0]  wk_valc_d, wk_valp_d;

  stat_e        stat_q, fin_stat;
  logic         xfer, finish;
  logic [3:0]   dec_icode, len;
  logic         need_regids, need_valc, invalid;
  logic [2:0]   valc_ofs;

  assign xfer = (state_q == S_FETCH) && imem_ack;

  // Byte 0 is classified straight off the bus; later bytes use the latched icode
  assign dec_icode = (idx_q == 4'd0) ? imem_data[7:4] : wk_icode_q;

  // Position of the current byte inside valc; modulo-8 arithmetic covers
  // byte indices 1..8 (no register byte) and 2..9 (with register byte).
  assign valc_ofs = idx_q[2:0] - (need_regids ? 3'd2 : 3'd1);

  instr_length u_instr_length (
    .icode       (dec_icode),
    .length      (len),
    .need_regids (need_regids),
    .need_valc   (need_valc),
    .invalid     (invalid)
  );

  assign stat = stat_q;

  // FSM state register
  always_ff @(posedge clock) begin
    // NOTE: registered state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state, memory request, completion detection and status outputs
  always_comb begin
    state_d     = state_q;
    finish      = 1'b0;
    fin_stat    = STAT_AOK;
    imem_req    = 1'b0;
    imem_addr   = '0;
    busy        = 1'b1;
    instr_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (pc_load) state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req  = 1'b1;
        imem_addr = pc_q + {60'd0, idx_q};
        if (imem_ack) begin
          if (imem_err) begin
            finish   = 1'b1;
            fin_stat = STAT_ADR;
          end else if (idx_q == 4'd0 && invalid) begin
            finish   = 1'b1;
            fin_stat = STAT_INS;
          end else if (idx_q == 4'd0 && dec_icode == I_HALT) begin
            finish   = 1'b1;
            fin_stat = STAT_HLT;
          end else if (idx_q == len - 4'd1) begin
            finish   = 1'b1;
            fin_stat = STAT_AOK;
          end
          if (finish) state_d = S_DONE;
        end
      end
      S_DONE: begin
        instr_valid = 1'b1;
        state_d     = (stat_q == STAT_AOK) ? S_IDLE : S_HALTED;
      end
      S_HALTED: busy = 1'b0;
      default:  state_d = S_IDLE;
    endcase
  end

  // Next contents of the working decode registers for the byte on the bus
  always_comb begin
    wk_icode_d = wk_icode_q;
    wk_ifun_d  = wk_ifun_q;
    wk_ra_d    = wk_ra_q;
    wk_rb_d    = wk_rb_q;
    wk_valc_d  = wk_valc_q;
    wk_valp_d  = wk_valp_q;
    if (xfer && !imem_err) begin
      if (idx_q == 4'd0) begin
        wk_icode_d = imem_data[7:4];
        wk_ifun_d  = imem_data[3:0];
        wk_ra_d    = REG_NONE;
        wk_rb_d    = REG_NONE;
        wk_valc_d  = '0;
        wk_valp_d  = pc_q + {60'd0, len};
      end else if (idx_q == 4'd1 && need_regids) begin
        wk_ra_d = imem_data[7:4];
        wk_rb_d = imem_data[3:0];
      end else if (need_valc) begin
        wk_valc_d[{valc_ofs, 3'b000} +: 8] = imem_data;
      end
    end
  end

  // PC, byte index, working registers and the held decoded outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      idx_q      <= '0;
      wk_icode_q <= '0;
      wk_ifun_q  <= '0;
      wk_ra_q    <= REG_NONE;
      wk_rb_q    <= REG_NONE;
      wk_valc_q  <= '0;
      wk_valp_q  <= '0;
      icode      <= '0;
      ifun       <= '0;
      ra         <= REG_NONE;
      rb         <= REG_NONE;
      valc       <= '0;
      valp       <= '0;
      stat_q     <= STAT_AOK;
    end else begin
      if (state_q == S_IDLE && pc_load) begin
        pc_q  <= pc_in;
        idx_q <= '0;
      end
      if (xfer) begin
        idx_q      <= idx_q + 4'd1;
        wk_icode_q <= wk_icode_d;
        wk_ifun_q  <= wk_ifun_d;
        wk_ra_q    <= wk_ra_d;
        wk_rb_q    <= wk_rb_d;
        wk_valc_q  <= wk_valc_d;
        wk_valp_q  <= wk_valp_d;
        if (finish) begin
          icode  <= wk_icode_d;
          ifun   <= wk_ifun_d;
          ra     <= wk_ra_d;
          rb     <= wk_rb_d;
          valc   <= wk_valc_d;
          valp   <= wk_valp_d;
          stat_q <= fin_stat;
        end
      end
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 64'd0: PC loaded on reset.
REQ-002 clock  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 pc_in  input  64  next PC from the PC-update stage.
REQ-005 pc_load  input  1  one-cycle strobe: latch pc_in and start a fetch.
REQ-006 imem_req  output  1  byte-read request to instruction memory.
REQ-007 imem_addr  output  64  byte address of the current request.
REQ-008 imem_ack  input  1  memory accepted the request; data is valid this cycle.
REQ-009 imem_data  input  8  returned byte.
REQ-010 imem_err  input  1  address error, qualified by imem_ack.
REQ-011 icode, ifun, ra, rb  output  4 each  decoded instruction fields.
REQ-012 valc  output  64  constant word; valp  output  64  address of the next sequential instruction.
REQ-013 instr_valid  output  1  one-cycle pulse when all decoded outputs are valid.
REQ-014 stat  output  3  status: AOK=1, HLT=2, ADR=3, INS=4.
REQ-015 busy  output  1  high in every state except IDLE and HALTED.

Function
REQ-016 The block SHALL implement the states IDLE, FETCH, DONE and HALTED.
REQ-017 In IDLE, pc_load SHALL latch pc_in into the PC register, clear the byte index, and move to FETCH.
REQ-018 In FETCH, the block SHALL hold imem_req high with imem_addr = PC + byte index; a byte SHALL transfer on every cycle where imem_req and imem_ack are both high.
REQ-019 imem_addr SHALL stay stable until imem_ack is seen; while ack is low, the block SHALL wait indefinitely.
REQ-020 Byte 0 SHALL give icode = bits [7:4] and ifun = bits [3:0].
REQ-021 Instruction lengths SHALL be:
- halt, nop, ret: 1 byte
- cmovxx, opq, pushq, popq: 2 bytes
- jxx, call: 9 bytes
- irmovq, rmmovq, mrmovq: 10 bytes
REQ-022 For 2- and 10-byte instructions, byte 1 SHALL supply ra = [7:4] and rb = [3:0]; otherwise ra and rb SHALL be 4'hF.
REQ-023 valc SHALL be assembled little-endian from bytes 1–8 (jxx, call) or bytes 2–9 (irmovq, rmmovq, mrmovq); otherwise valc SHALL be 0.
REQ-024 valp SHALL equal PC + length, computed modulo 2^64; the PC register itself SHALL be allowed to wrap.
REQ-025 After the last byte transfers, the block SHALL enter DONE, pulse instr_valid for exactly one cycle with stat=AOK, then return to IDLE.
REQ-026 icode=0 (halt) SHALL give stat=HLT with instr_valid, then enter HALTED.
REQ-027 icode>11 SHALL stop fetching after byte 0 and give stat=INS with instr_valid, then enter HALTED.
REQ-028 imem_err with imem_ack on any byte SHALL abort the fetch and give stat=ADR with instr_valid, then enter HALTED; fields decoded so far SHALL be held and remaining fields are don't-care.
REQ-029 HALTED SHALL keep imem_req=0 and ignore pc_load until reset.
REQ-030 pc_load while busy SHALL be ignored.
REQ-031 Latency: with imem_ack held high and pc_load at edge t, a 1-byte instruction SHALL pulse instr_valid in cycle t+2, and an N-byte instruction in cycle t+N+1.
REQ-032 Decoded outputs SHALL hold their values between instr_valid pulses.

Reset
REQ-033 Reset SHALL force:
- state IDLE; PC = RESET_PC
- imem_req=0, imem_addr=0
- icode=0, ifun=0, ra=rb=4'hF, valc=0, valp=0
- instr_valid=0, stat=AOK, busy=0
REQ-034 Reset asserted mid-fetch SHALL abandon the fetch on that edge with no instr_valid pulse.

Structure
REQ-035 Icode constants, stat codes and instruction lengths SHALL live in shared package y86_pkg.
REQ-036 A combinational sub-module instr_length SHALL map icode to {length, need_regids, need_valc, invalid}.

Verification
REQ-037 pc_load, pc_in=0x100, memory bytes 30 F3 08 07 06 05 04 03 02 01, ack always high -> instr_valid in cycle t+11 with icode=3, ra=F, rb=3, valc=0x0102030405060708, valp=0x10A.
REQ-038 pc_in=0x20, bytes 70 00 01 00 00 00 00 00 00 (jmp) -> valc=0x100, valp=0x29, ra=rb=F.
REQ-039 Same as REQ-037 with ack low for 3 cycles before byte 4 -> imem_addr=0x104 held stable throughout; instr_valid delayed exactly 3 cycles; results identical.
REQ-040 Byte 0 = 0xC0 -> stat=INS after one byte; imem_req stays 0 afterwards; a later pc_load is ignored.
REQ-041 imem_err on byte 2 of an irmovq -> stat=ADR and state HALTED; then reset -> all outputs at reset values and a normal nop fetch (byte 0x10) gives valp=PC+1.
REQ-042 pc_in=0xFFFF_FFFF_FFFF_FFFF with a 2-byte opq (bytes 60 01) -> second byte fetched from address 0, valp=0x1.
